// File: rtl/imager_pkg.sv
// Shared types and constants for the pixel word packer.
// PACKER_EOF_MARKER_EN adds the MARK state that appends an end-of-frame marker word.
package imager_pkg;

   localparam int unsigned LANES     = 4;
   localparam int unsigned PIXEL_W   = 8;
   localparam int unsigned WORD_W    = LANES * PIXEL_W;
   localparam int unsigned PARTIAL_W = (LANES - 1) * PIXEL_W;
   localparam int unsigned LANE_W    = $clog2(LANES);
   localparam logic [7:0]  EOF_MARKER = 8'hA5;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PACK  = 3'd1,
      FLUSH = 3'd2,
      DRAIN = 3'd3
`ifdef PACKER_EOF_MARKER_EN
      , MARK = 3'd4
`endif
   } state_t;

   // Keep only the lanes already filled; upper lanes become zero.
   function automatic logic [WORD_W-1:0] pad_partial(input logic [PARTIAL_W-1:0] bytes,
                                                     input logic [LANE_W-1:0] filled);
      case (filled)
         2'd1:    return {24'h0, bytes[7:0]};
         2'd2:    return {16'h0, bytes[15:0]};
         2'd3:    return {8'h0, bytes[23:0]};
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/pixel_word_packer_if.sv
// Packed-word stream: master offers word_data/word_valid, slave answers with word_ready.
interface pixel_word_packer_if;
   import imager_pkg::*;

   logic              word_valid;
   logic [WORD_W-1:0] word_data;
   logic              word_ready;

   modport master (output word_valid, output word_data, input word_ready);
   modport slave  (input word_valid, input word_data, output word_ready);

endinterface

// File: rtl/packer_word_buffer.sv
// Circular word buffer of DEPTH entries (power of 2); push and pop may share a cycle even when full.
module packer_word_buffer
   import imager_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              push,
   input  logic [WORD_W-1:0] push_data,
   input  logic              pop,
   output logic [WORD_W-1:0] head,
   output logic              full,
   output logic              empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WORD_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   // Storage needs no reset: head is masked while empty.
   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/pixel_word_packer.sv
// Packs 8-bit ADC pixels little-endian into 32-bit words, flushes partial words at frame end.
// PACKER_EOF_MARKER_EN appends a {A5, 00, word_count} marker word after each flush.
module pixel_word_packer
   import imager_pkg::*;
#(
   parameter int unsigned OUT_DEPTH = 4,
   parameter int unsigned COUNT_W   = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       frame_start,
   input  logic                       pixel_valid,
   input  logic [PIXEL_W-1:0]         pixel_data,
   input  logic                       frame_done,
   pixel_word_packer_if.master        word_bus,
   output logic                       overflow,
   input  logic                       overflow_clear,
   output logic [COUNT_W-1:0]         word_count,
   output logic                       frame_packed,
   output logic                       busy
);

   state_t                state;
   logic [LANE_W-1:0]     lane;
   logic [PARTIAL_W-1:0]  partial;
   logic                  full;
   logic                  empty;
   logic                  pop;
   logic                  can_push;
   logic                  last_lane;
   logic                  push;
   logic                  clear;
   logic [WORD_W-1:0]     push_word;
   logic [WORD_W-1:0]     head;
   logic [COUNT_W-1:0]    count_inc;

   assign pop       = !empty && word_bus.word_ready;
   assign can_push  = !full || pop;
   assign last_lane = (lane == LANE_W'(LANES - 1));
   assign count_inc = (word_count == '1) ? word_count : word_count + COUNT_W'(1);

   assign word_bus.word_valid = !empty;
   assign word_bus.word_data  = head;

   // Buffer write port: which word, if any, enters the buffer this cycle.
   always_comb begin
      push      = 1'b0;
      clear     = 1'b0;
      push_word = '0;
      if (frame_start && state != IDLE) begin
         clear = 1'b1;
      end else begin
         case (state)
            PACK: if (pixel_valid && last_lane && can_push) begin
               push      = 1'b1;
               push_word = {pixel_data, partial};
            end
            FLUSH: if (!full && lane != '0) begin
               push      = 1'b1;
               push_word = pad_partial(partial, lane);
            end
`ifdef PACKER_EOF_MARKER_EN
            MARK: if (!full) begin
               push      = 1'b1;
               push_word = {EOF_MARKER, 8'h00, 16'(word_count)};
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         lane         <= '0;
         partial      <= '0;
         overflow     <= 1'b0;
         word_count   <= '0;
         frame_packed <= 1'b0;
         busy         <= 1'b0;
      end else begin
         frame_packed <= 1'b0;
         if (overflow_clear) overflow <= 1'b0;
         if (frame_start) begin
            state      <= PACK;
            lane       <= '0;
            word_count <= '0;
            busy       <= 1'b1;
         end else begin
            case (state)
               IDLE: ;
               PACK: begin
                  if (pixel_valid) begin
                     lane <= lane + LANE_W'(1);
                     case (lane)
                        2'd0:    partial[7:0]   <= pixel_data;
                        2'd1:    partial[15:8]  <= pixel_data;
                        2'd2:    partial[23:16] <= pixel_data;
                        default: ;
                     endcase
                     // A completed word with no room is dropped and not counted.
                     if (last_lane) begin
                        if (can_push) word_count <= count_inc;
                        else          overflow   <= 1'b1;
                     end
                  end
                  if (frame_done) state <= FLUSH;
               end
               FLUSH: if (!full) begin
                  if (lane != '0) word_count <= count_inc;
                  lane <= '0;
`ifdef PACKER_EOF_MARKER_EN
                  state <= MARK;
`else
                  state <= DRAIN;
`endif
               end
`ifdef PACKER_EOF_MARKER_EN
               MARK: if (!full) state <= DRAIN;
`endif
               DRAIN: if (empty) begin
                  frame_packed <= 1'b1;
                  busy         <= 1'b0;
                  state        <= IDLE;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   packer_word_buffer #(
      .DEPTH (OUT_DEPTH)
   ) u_buffer (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .push      (push),
      .push_data (push_word),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty)
   );

endmodule
